mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 16'h0000, RAM word address of the first loaded word.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  one-cycle pulse; restarts a load from DONE or ERR.
REQ-005 SHALL have port BYTE_IN  input  8  incoming program-stream byte.
REQ-006 SHALL have port BYTE_VALID  input  1  BYTE_IN is valid this cycle.
REQ-007 SHALL have port BYTE_READY  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port RAM_ADDR  output  16  RAM word address.
REQ-009 SHALL have port RAM_DATABUS_OUT  output  32  word written to RAM.
REQ-010 SHALL have port RAM_RW_  output  1  0 = write strobe, 1 = read/idle.
REQ-011 SHALL have port CPU_RESET  output  1  active-low reset to CPU_32; low while loading.
REQ-012 SHALL have port DONE  output  1  load completed with valid checksum.
REQ-013 SHALL have port ERROR  output  1  load ended with checksum mismatch.

Function
REQ-014 SHALL accept a byte only on a rising edge where BYTE_VALID and BYTE_READY are both 1; bytes offered while BYTE_READY=0 are not consumed.
REQ-015 SHALL decode the stream: LEN_HI, LEN_LO (16-bit word count N, big-endian), N words of 4 bytes each (big-endian, MSB first), one checksum byte.
REQ-016 SHALL implement states LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR.
REQ-017 SHALL transition LEN_HI->LEN_LO->DATA on accepted bytes; LEN_LO->CHECK directly when N=0.
REQ-018 SHALL, in DATA, shift bytes into a 32-bit assembly register with a 2-bit byte counter; 4th byte -> WRITE.
REQ-019 SHALL, in WRITE, drive RAM_RW_=0, RAM_ADDR=ADDR_BASE+index, RAM_DATABUS_OUT=assembled word for exactly one cycle, with BYTE_READY=0.
REQ-020 SHALL, after WRITE, increment index; go to CHECK if index equals N, else DATA.
REQ-021 SHALL compute address as (ADDR_BASE+index) modulo 2^16; wrap past 16'hFFFF is silent.
REQ-022 SHALL keep checksum as XOR of all data bytes only (length bytes excluded); initial value 8'h00.
REQ-023 SHALL, in CHECK, compare the accepted byte to the checksum: equal -> DONE, else -> ERR.
REQ-024 SHALL drive BYTE_READY=1 in LEN_HI, LEN_LO, DATA, CHECK; 0 in WRITE, DONE, ERR.
REQ-025 SHALL drive CPU_RESET=0 in all states except DONE, where it is 1.
REQ-026 SHALL drive DONE=1 only in DONE, ERROR=1 only in ERR.
REQ-027 SHALL, on START in DONE or ERR, go to LEN_HI next cycle, clearing index, byte counter, checksum; CPU_RESET falls that same edge.
REQ-028 SHALL ignore START in all other states.
REQ-029 SHALL hold RAM_RW_=1 outside WRITE; RAM_ADDR and RAM_DATABUS_OUT hold last value.

Reset
REQ-030 SHALL, on RESET=0 at any time including mid-load, immediately enter LEN_HI with index=0, byte counter=0, checksum=0, assembly register=0.
REQ-031 SHALL reset outputs: BYTE_READY=1 after release (0 while RESET=0), RAM_ADDR=ADDR_BASE, RAM_DATABUS_OUT=0, RAM_RW_=1, CPU_RESET=0, DONE=0, ERROR=0.
REQ-032 SHALL not write RAM for a partially assembled word interrupted by reset.

Verification
REQ-033 Stream 00 01 DE AD BE EF 22 -> one write cycle RAM_ADDR=0000, data=DEADBEEF, RAM_RW_=0; then DONE=1, CPU_RESET=1.
REQ-034 Stream 00 02 00 00 00 01 00 00 00 02 03 with BYTE_VALID toggling every other cycle -> writes 00000001@0000, 00000002@0001; DONE=1.
REQ-035 Stream 00 01 12 34 56 78 00 -> write 12345678@0000, then ERROR=1, CPU_RESET stays 0; START pulse -> LEN_HI, ERROR=0.
REQ-036 Stream 00 00 00 -> no RAM write, DONE=1; stream 00 00 01 -> ERROR=1.
REQ-037 ADDR_BASE=FFFF, stream 00 02 + two words -> writes at FFFF then 0000.
REQ-038 RESET pulsed low after 2 data bytes -> no write, all outputs at reset values; fresh full stream then loads correctly.

Source files
------------

// File: rtl/mem_loader.sv
// Byte-stream program loader: decodes length, data words and checksum,
// writes words into RAM and holds the CPU in reset until a clean load.
module mem_loader #(
  parameter logic [15:0] ADDR_BASE = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic [15:0] RAM_ADDR,
  output logic [31:0] RAM_DATABUS_OUT,
  output logic        RAM_RW_,
  output logic        CPU_RESET,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [1:0]  r_cnt;
  logic [7:0]  r_csum;
  logic [31:0] r_asm;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_ready;
  logic        w_accept;
  logic        w_restart;
  logic [15:0] w_idx_nx;
  logic [15:0] w_len_full;
  logic [31:0] w_word;

  assign w_accept   = BYTE_VALID & w_ready;
  assign w_restart  = START &
                      ((r_state == S_DONE) |
                       (r_state == S_ERR));
  assign w_idx_nx   = r_idx + 16'd1;
  assign w_len_full = {r_len[15:8], BYTE_IN};
  assign w_word     = {r_asm[23:0], BYTE_IN};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_LEN_HI;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    RAM_RW_   = 1'b1;
    CPU_RESET = 1'b0;
    DONE      = 1'b0;
    ERROR     = 1'b0;
    case (r_state)
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (w_accept) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (w_accept)
          w_next = (w_len_full == 16'd0) ?
                   S_CHECK : S_DATA;
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_accept && r_cnt == 2'd3)
          w_next = S_WRITE;
      end
      S_WRITE: begin
        RAM_RW_ = 1'b0;
        w_next  = (w_idx_nx == r_len) ?
                  S_CHECK : S_DATA;
      end
      S_CHECK: begin
        w_ready = 1'b1;
        if (w_accept)
          w_next = (BYTE_IN == r_csum) ?
                   S_DONE : S_ERR;
      end
      S_DONE: begin
        CPU_RESET = 1'b1;
        DONE      = 1'b1;
        if (w_restart) w_next = S_LEN_HI;
      end
      S_ERR: begin
        ERROR = 1'b1;
        if (w_restart) w_next = S_LEN_HI;
      end
      default: w_next = S_LEN_HI;
    endcase
  end

  // ready is forced low while reset is held, independent of state
  assign BYTE_READY = w_ready & RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_asm   <= '0;
      r_addr  <= ADDR_BASE;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_LEN_HI: begin
          if (w_accept) r_len[15:8] <= BYTE_IN;
        end
        S_LEN_LO: begin
          if (w_accept) r_len[7:0] <= BYTE_IN;
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm  <= w_word;
            r_cnt  <= r_cnt + 2'd1;
            r_csum <= r_csum ^ BYTE_IN;
            // latch the write bus as the word completes
            if (r_cnt == 2'd3) begin
              r_addr  <= ADDR_BASE + r_idx;
              r_wdata <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_nx;
        end
        S_DONE, S_ERR: begin
          if (w_restart) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_csum <= '0;
            r_asm  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign RAM_ADDR        = r_addr;
  assign RAM_DATABUS_OUT = r_wdata;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (base 0000 and FFFF)
// driven by the same byte streams, writes captured and compared.
module tb_mem_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  BYTE_IN = 8'h00;
  logic        BYTE_VALID = 1'b0;

  logic        BYTE_READY;
  logic [15:0] RAM_ADDR;
  logic [31:0] RAM_DATABUS_OUT;
  logic        RAM_RW_;
  logic        CPU_RESET;
  logic        DONE;
  logic        ERROR;

  logic        rdy2;
  logic [15:0] addr2;
  logic [31:0] data2;
  logic        rw2;
  logic        cpu2;
  logic        done2;
  logic        err2;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] q_a[$];
  logic [31:0] q_d[$];
  logic [15:0] q_a2[$];

  always #5 CLK = ~CLK;

  mem_loader #(.ADDR_BASE(16'h0000)) u_dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .RAM_ADDR(RAM_ADDR),
    .RAM_DATABUS_OUT(RAM_DATABUS_OUT),
    .RAM_RW_(RAM_RW_), .CPU_RESET(CPU_RESET),
    .DONE(DONE), .ERROR(ERROR)
  );

  mem_loader #(.ADDR_BASE(16'hFFFF)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .START(START),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(rdy2), .RAM_ADDR(addr2),
    .RAM_DATABUS_OUT(data2),
    .RAM_RW_(rw2), .CPU_RESET(cpu2),
    .DONE(done2), .ERROR(err2)
  );

  always @(negedge CLK) begin
    if (!RAM_RW_) begin
      q_a.push_back(RAM_ADDR);
      q_d.push_back(RAM_DATABUS_OUT);
    end
    if (!rw2) q_a2.push_back(addr2);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge CLK);
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    while (!BYTE_READY && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'(BYTE_READY), 1);
    @(posedge CLK);
    #1;
    BYTE_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_seq(input logic [7:0] s[], input int gap);
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic clr_q();
    q_a.delete();
    q_d.delete();
    q_a2.delete();
  endtask

  task automatic chk_status(input string tag,
                            input logic d, input logic e,
                            input logic c, input logic r);
    @(negedge CLK);
    chk({tag, "_done"}, 32'(DONE), 32'(d));
    chk({tag, "_error"}, 32'(ERROR), 32'(e));
    chk({tag, "_cpurst"}, 32'(CPU_RESET), 32'(c));
    chk({tag, "_ready"}, 32'(BYTE_READY), 32'(r));
  endtask

  task automatic chk_reset_vals(input string tag,
                                input logic rdy);
    chk({tag, "_ready"}, 32'(BYTE_READY), 32'(rdy));
    chk({tag, "_addr"}, 32'(RAM_ADDR), 32'h0000);
    chk({tag, "_addr2"}, 32'(addr2), 32'hFFFF);
    chk({tag, "_data"}, RAM_DATABUS_OUT, 32'h0);
    chk({tag, "_rw"}, 32'(RAM_RW_), 1);
    chk({tag, "_cpurst"}, 32'(CPU_RESET), 0);
    chk({tag, "_done"}, 32'(DONE), 0);
    chk({tag, "_error"}, 32'(ERROR), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[];

    repeat (2) @(negedge CLK);
    chk_reset_vals("rst_hold", 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    chk_reset_vals("rst_rel", 1'b1);

    // single word, good checksum
    clr_q();
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_seq(s, 0);
    chk_status("w1", 1, 0, 1, 0);
    chk("w1_nwr", q_a.size(), 1);
    if (q_a.size() == 1) begin
      chk("w1_addr", 32'(q_a[0]), 32'h0000);
      chk("w1_data", q_d[0], 32'hDEADBEEF);
      chk("w1_addr2", 32'(q_a2[0]), 32'hFFFF);
    end
    chk("w1_rw_idle", 32'(RAM_RW_), 1);
    chk("w1_hold", RAM_DATABUS_OUT, 32'hDEADBEEF);
    pulse_start();
    chk_status("w1_st", 0, 0, 0, 1);

    // two words, valid gapped every other cycle
    clr_q();
    s = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
          8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    send_seq(s, 1);
    chk_status("w2", 1, 0, 1, 0);
    chk("w2_nwr", q_a.size(), 2);
    if (q_a.size() == 2) begin
      chk("w2_a0", 32'(q_a[0]), 32'h0000);
      chk("w2_d0", q_d[0], 32'h00000001);
      chk("w2_a1", 32'(q_a[1]), 32'h0001);
      chk("w2_d1", q_d[1], 32'h00000002);
      chk("w2_wrap0", 32'(q_a2[0]), 32'hFFFF);
      chk("w2_wrap1", 32'(q_a2[1]), 32'h0000);
    end
    pulse_start();

    // bad checksum
    clr_q();
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    send_seq(s, 0);
    chk_status("bad", 0, 1, 0, 0);
    chk("bad_nwr", q_a.size(), 1);
    if (q_a.size() == 1)
      chk("bad_data", q_d[0], 32'h12345678);
    repeat (3) @(negedge CLK);
    chk("bad_cpu_hold", 32'(CPU_RESET), 0);
    pulse_start();
    chk_status("bad_st", 0, 0, 0, 1);

    // zero length, START mid-stream must be ignored
    clr_q();
    send(8'h00, 0);
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    chk_status("z0", 1, 0, 1, 0);
    chk("z0_nwr", q_a.size(), 0);
    pulse_start();

    clr_q();
    s = '{8'h00, 8'h00, 8'h01};
    send_seq(s, 0);
    chk_status("z1", 0, 1, 0, 0);
    chk("z1_nwr", q_a.size(), 0);
    pulse_start();

    // reset in the middle of a word
    clr_q();
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_seq(s, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk_reset_vals("mid_rst", 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk_reset_vals("mid_rel", 1'b1);
    chk("mid_nwr", q_a.size(), 0);

    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_seq(s, 0);
    chk_status("post", 1, 0, 1, 0);
    chk("post_nwr", q_a.size(), 1);
    if (q_a.size() == 1) begin
      chk("post_addr", 32'(q_a[0]), 32'h0000);
      chk("post_data", q_d[0], 32'hDEADBEEF);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
